memory_stage: RTL and testbench

//  MEM stage of the 5-stage pipeline: consumes the execute stage's result (address or ALU

---
 rtl/memory_stage.sv | 106 ++++++++++
 tb/tb_memory_stage.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// memory_stage: MEM stage. Word loads and stores on a local data RAM, plus the MEM/WB register.
// Optional MEM_RESET_EN: zeroes the RAM one word per cycle after reset, with busy high while it clears.
module memory_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int REG_W  = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stall,
    input  logic [DATA_W-1:0] result,
    input  logic [DATA_W-1:0] registro_2_out,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              reg_write,
    input  logic [REG_W-1:0]  rd,
    output logic [DATA_W-1:0] wb_data,
    output logic [REG_W-1:0]  wb_rd,
    output logic              wb_reg_write,
    output logic              mem_error,
    output logic              busy
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_wb_data;
    logic [REG_W-1:0]  r_wb_rd;
    logic              r_wb_reg_write;
    logic              r_mem_error;

    logic [ADDR_W-1:0] w_addr;
    logic              w_misaligned;
    logic              w_hold;
    logic              w_store;
    logic              w_load;

    // Upper address bits are dropped, so accesses wrap modulo the RAM depth.
    assign w_addr       = result[ADDR_W+1:2];
    assign w_misaligned = (mem_read | mem_write) & (result[1:0] != 2'b00);
    assign w_hold       = stall | busy;
    assign w_store      = mem_write & ~w_misaligned & ~w_hold;
    assign w_load       = mem_read & ~mem_write & ~w_misaligned;

`ifdef MEM_RESET_EN
    typedef enum logic {S_CLEAR, S_RUN} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_clr_addr;
    logic              w_clearing;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= S_CLEAR;
            r_clr_addr <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_clearing) r_clr_addr <= r_clr_addr + 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clearing  = 1'b0;
        if (r_state == S_CLEAR) begin
            w_clearing = 1'b1;
            if (r_clr_addr == '1) w_state_nxt = S_RUN;
        end
    end

    assign busy = reset & w_clearing;

    // The clear sweep owns the write port. Busy keeps w_store low during the sweep.
    always_ff @(posedge clock) begin
        if (w_clearing)   r_mem[r_clr_addr] <= '0;
        else if (w_store) r_mem[w_addr]     <= registro_2_out;
    end
`else
    assign busy = 1'b0;

    always_ff @(posedge clock) begin
        if (w_store) r_mem[w_addr] <= registro_2_out;
    end
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wb_data      <= '0;
            r_wb_rd        <= '0;
            r_wb_reg_write <= 1'b0;
            r_mem_error    <= 1'b0;
        end else if (busy) begin
            r_wb_reg_write <= 1'b0;
        end else if (!stall) begin
            r_wb_data      <= w_load ? r_mem[w_addr] : result;
            r_wb_rd        <= rd;
            r_wb_reg_write <= reg_write & ~mem_write & ~w_misaligned;
            r_mem_error    <= r_mem_error | w_misaligned;
        end
    end

    assign wb_data      = r_wb_data;
    assign wb_rd        = r_wb_rd;
    assign wb_reg_write = r_wb_reg_write;
    assign mem_error    = r_mem_error;
endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: a reference model pushes the expected MEM/WB contents
// and the bench pops and compares them after every edge. Also covers the optional RAM-clear sweep.
module tb_memory_stage;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;
    localparam int REG_W  = 5;
    localparam int DEPTH  = 2 ** ADDR_W;

    logic              clock = 1'b0;
    logic              reset;
    logic              stall;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] registro_2_out;
    logic              mem_read;
    logic              mem_write;
    logic              reg_write;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] wb_data;
    logic [REG_W-1:0]  wb_rd;
    logic              wb_reg_write;
    logic              mem_error;
    logic              busy;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [REG_W-1:0]  rd;
        logic              we;
        logic              chk_data;
    } exp_t;

    exp_t              q[$];
    exp_t              m_last;
    logic [DATA_W-1:0] m_mem [DEPTH];
    logic              m_err;
    int                n_tests = 0;
    int                n_fail  = 0;

    memory_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_W(REG_W)) dut (
        .clock(clock), .reset(reset), .stall(stall), .result(result),
        .registro_2_out(registro_2_out), .mem_read(mem_read), .mem_write(mem_write),
        .reg_write(reg_write), .rd(rd), .wb_data(wb_data), .wb_rd(wb_rd),
        .wb_reg_write(wb_reg_write), .mem_error(mem_error), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Drive one instruction for one edge. The model predicts MEM/WB, then the bench compares.
    task automatic send(input logic st, input logic mr, input logic mw, input logic rw,
                        input logic [DATA_W-1:0] res, input logic [DATA_W-1:0] d,
                        input logic [REG_W-1:0] r, input string tag);
        exp_t        e;
        logic        mis;
        int          a;
        mis = (mr | mw) && (res[1:0] != 2'b00);
        a   = int'(res[ADDR_W+1:2]);
        stall = st; mem_read = mr; mem_write = mw; reg_write = rw;
        result = res; registro_2_out = d; rd = r;
        if (st) begin
            e = m_last;
        end else begin
            e.rd       = r;
            e.we       = rw & ~mw & ~mis;
            e.chk_data = !(mw || mis);
            e.data     = (mr && !mw && !mis) ? m_mem[a] : res;
            if (mis) m_err = 1'b1;
            if (mw && !mis) m_mem[a] = d;
        end
        m_last = e;
        q.push_back(e);
        @(posedge clock); #1;
        e = q.pop_front();
        if (e.chk_data) check({tag, ".data"}, wb_data, e.data);
        check({tag, ".rd"}, {27'd0, wb_rd}, {27'd0, e.rd});
        check({tag, ".we"}, {31'd0, wb_reg_write}, {31'd0, e.we});
        check({tag, ".err"}, {31'd0, mem_error}, {31'd0, m_err});
    endtask

    task automatic idle_inputs();
        stall = 1'b0; mem_read = 1'b0; mem_write = 1'b0; reg_write = 1'b0;
        result = '0; registro_2_out = '0; rd = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".wb_data"}, wb_data, '0);
        check({tag, ".wb_rd"}, {27'd0, wb_rd}, '0);
        check({tag, ".wb_we"}, {31'd0, wb_reg_write}, '0);
        check({tag, ".err"}, {31'd0, mem_error}, '0);
        check({tag, ".busy"}, {31'd0, busy}, '0);
    endtask

    task automatic wait_clear(input string tag);
        int n;
        n = 0;
`ifdef MEM_RESET_EN
        check({tag, ".busy_start"}, {31'd0, busy}, 32'd1);
`else
        check({tag, ".busy_start"}, {31'd0, busy}, 32'd0);
`endif
        while (busy && n < 100) begin
            @(posedge clock); #1;
            n++;
        end
`ifdef MEM_RESET_EN
        check({tag, ".clear_cycles"}, n, DEPTH);
`else
        check({tag, ".clear_cycles"}, n, 0);
`endif
    endtask

    initial begin
        reset = 1'b0;
        m_err = 1'b0;
        m_last = '0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        // Test 1: random inputs while held in reset.
        for (int i = 0; i < 4; i++) begin
            stall = 1'($urandom); mem_read = 1'($urandom); mem_write = 1'($urandom);
            reg_write = 1'($urandom); result = $urandom; registro_2_out = $urandom;
            rd = 5'($urandom);
            @(posedge clock); #1;
        end
        check_reset_outputs("reset");
        idle_inputs();
        reset = 1'b1;
        wait_clear("clear0");

`ifdef MEM_RESET_EN
        // Test 6: a reset pulse partway through the sweep restarts the full count.
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin @(posedge clock); #1; end
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin @(posedge clock); #1; end
        reset = 1'b0;
        #2;
        check_reset_outputs("midclear_rst");
        @(posedge clock); #1;
        reset = 1'b1;
        wait_clear("clear1");
        send(0, 1, 0, 1, 32'h3C, 32'h0, 5'd1, "ld_cleared");
`endif

        // Test 2: store, then an immediate load of the same word.
        send(0, 0, 1, 1, 32'h8, 32'hDEADBEEF, 5'd9, "st8");
        send(0, 1, 0, 1, 32'h8, 32'h0, 5'd3, "ld8");
        // Test 3: plain ALU op passes through.
        send(0, 0, 0, 1, 32'h4, 32'h0, 5'd7, "alu");
        // Address wrap: 0x48 maps onto the same word as 0x8.
        send(0, 0, 1, 0, 32'h48, 32'h12345678, 5'd2, "st_wrap");
        send(0, 1, 0, 1, 32'h8, 32'h0, 5'd4, "ld_wrap");
        // Read and write together acts as a store: no write-back, no error.
        send(0, 1, 1, 1, 32'h10, 32'hCAFEF00D, 5'd5, "rdwr");
        send(0, 1, 0, 1, 32'h10, 32'h0, 5'd6, "ld_rdwr");
        // Test 4: a misaligned store must not modify the RAM. The error flag is sticky.
        send(0, 0, 1, 0, 32'h4, 32'hA5A5A5A5, 5'd0, "st4");
        send(0, 0, 1, 1, 32'h6, 32'h5A5A5A5A, 5'd8, "st_mis");
        send(0, 1, 0, 1, 32'h4, 32'h0, 5'd10, "ld4");
        send(0, 1, 0, 1, 32'h1, 32'h0, 5'd11, "ld_mis");
        send(0, 0, 0, 1, 32'hFF00, 32'h0, 5'd12, "alu2");
        // Test 5: a stall freezes MEM/WB and blocks the store.
        send(0, 0, 1, 0, 32'h0, 32'h11, 5'd0, "st0");
        send(0, 0, 0, 1, 32'h77, 32'h0, 5'd13, "alu3");
        send(1, 0, 1, 0, 32'h0, 32'h55, 5'd14, "stall_st");
        send(1, 0, 0, 1, 32'h99, 32'h0, 5'd15, "stall_alu");
        send(0, 1, 0, 1, 32'h0, 32'h0, 5'd16, "ld0");
        // Random aligned traffic over addresses already written.
        for (int i = 0; i < 20; i++) begin
            logic [DATA_W-1:0] ra;
            ra = {26'd0, 2'($urandom_range(0, 3)) == 2'd3 ? 4'd1 : 4'd2, 2'b00};
            send(1'($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
                 ra, $urandom, 5'($urandom), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
